// File: rtl/tlul_mem_tester_pkg.sv
// FSM states, TL-UL opcode/size constants and the data pattern used by the
// memory tester.
package tlul_mem_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        DONE
    } state_e;

    localparam logic [2:0] OP_PUT_FULL_DATA   = 3'h0;
    localparam logic [2:0] OP_GET             = 3'h4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'h0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'h1;
    localparam logic [1:0] SIZE_WORD          = 2'd2;
    localparam logic [3:0] MASK_WORD          = 4'hF;

    // Address-dependent pattern so that aliased or swapped words show up as errors.
    function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by hosts and devices in this slice.
// Field widths follow the common 32-bit data / 32-bit address TL-UL profile.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;

    localparam logic [TL_AUW-1:0] TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_mem_tester.sv
// Write-then-readback memory tester acting as a TL-UL host: writes a pattern
// over a word range, reads it back, and reports mismatches and timeouts.
module tlul_mem_tester
    import tlul_pkg::*;
    import tlul_mem_tester_pkg::*;
#(
    parameter int unsigned       TimeoutCycles = 1024,
    parameter logic [TL_AIW-1:0] SourceId      = '0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] num_words_i,
    input  logic [31:0] seed_i,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [31:0] first_err_addr_o
);

    localparam logic [31:0] WaitLast = 32'(TimeoutCycles) - 32'd1;

    state_e      state_reg, state_next;
    logic [31:0] cur_reg, cur_next;
    logic [31:0] base_reg, base_next;
    logic [31:0] seed_reg, seed_next;
    logic [31:0] n_reg, n_next;
    logic [31:0] idx_reg, idx_next;
    logic [31:0] wait_reg, wait_next;
    logic [15:0] err_count_reg, err_count_next;
    logic [31:0] first_err_reg, first_err_next;
    logic        timeout_reg, timeout_next;
    logic        rsp_err;
    logic        last_word;

    logic unused_tl;
    assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_source, tl_i.d_sink, tl_i.d_user};

    assign last_word = (idx_reg == n_reg - 32'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cur_reg       <= '0;
            base_reg      <= '0;
            seed_reg      <= '0;
            n_reg         <= '0;
            idx_reg       <= '0;
            wait_reg      <= '0;
            err_count_reg <= '0;
            first_err_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            base_reg      <= base_next;
            seed_reg      <= seed_next;
            n_reg         <= n_next;
            idx_reg       <= idx_next;
            wait_reg      <= wait_next;
            err_count_reg <= err_count_next;
            first_err_reg <= first_err_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        base_next      = base_reg;
        seed_next      = seed_reg;
        n_next         = n_reg;
        idx_next       = idx_reg;
        wait_next      = wait_reg;
        err_count_next = err_count_reg;
        first_err_next = first_err_reg;
        timeout_next   = timeout_reg;
        rsp_err        = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start_i) begin
                    base_next      = base_addr_i;
                    cur_next       = base_addr_i;
                    seed_next      = seed_i;
                    n_next         = num_words_i;
                    idx_next       = '0;
                    wait_next      = '0;
                    err_count_next = '0;
                    first_err_next = '0;
                    timeout_next   = 1'b0;
                    state_next     = (num_words_i == 32'd0) ? DONE : WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (tl_i.a_ready) begin
                    wait_next  = '0;
                    state_next = (state_reg == WR_REQ) ? WR_RSP : RD_RSP;
                end
            end
            WR_RSP, RD_RSP: begin
                if (tl_i.d_valid) begin
                    if (state_reg == WR_RSP) begin
                        rsp_err = tl_i.d_error || (tl_i.d_opcode != OP_ACCESS_ACK);
                    end else begin
                        rsp_err = tl_i.d_error || (tl_i.d_opcode != OP_ACCESS_ACK_DATA) ||
                                  (tl_i.d_data != pattern(cur_reg, seed_reg));
                    end
                    cur_next = cur_reg + 32'd4;
                    idx_next = idx_reg + 32'd1;
                    if (!last_word) begin
                        state_next = (state_reg == WR_RSP) ? WR_REQ : RD_REQ;
                    end else if (state_reg == WR_RSP) begin
                        // Write phase finished: rewind and start the readback pass.
                        cur_next   = base_reg;
                        idx_next   = '0;
                        state_next = RD_REQ;
                    end else begin
                        state_next = DONE;
                    end
                end else if (wait_reg == WaitLast) begin
                    timeout_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    wait_next = wait_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The first failing address is taken from the address of the response being judged.
        if (rsp_err) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_next = err_count_reg + 16'd1;
            end
            if (err_count_reg == 16'd0) begin
                first_err_next = cur_reg;
            end
        end
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = (state_reg == WR_REQ) || (state_reg == RD_REQ);
        tl_o.a_opcode  = (state_reg == RD_REQ) ? OP_GET : OP_PUT_FULL_DATA;
        tl_o.a_param   = '0;
        tl_o.a_size    = SIZE_WORD;
        tl_o.a_source  = SourceId;
        tl_o.a_address = cur_reg;
        tl_o.a_mask    = MASK_WORD;
        tl_o.a_data    = (state_reg == RD_REQ) ? '0 : pattern(cur_reg, seed_reg);
        tl_o.a_user    = TL_A_USER_DEFAULT;
        tl_o.d_ready   = (state_reg == WR_RSP) || (state_reg == RD_RSP);
    end

    assign busy_o           = (state_reg != IDLE) && (state_reg != DONE);
    assign done_o           = (state_reg == DONE);
    assign pass_o           = done_o && (err_count_reg == 16'd0) && !timeout_reg;
    assign timeout_o        = timeout_reg;
    assign err_count_o      = err_count_reg;
    assign first_err_addr_o = first_err_reg;

endmodule
